// File: rtl/rca_serial_add_ctrl_pkg.sv
// rtl/rca_serial_add_ctrl_pkg.sv - shared byte width and FSM encodings for the serial adder sequencer
package rca_serial_add_ctrl_pkg;

    localparam int BYTE_W = 8;

    // Encoding 2'd3 is unused; the FSM treats it as a recovery path back to idle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/RCA_8Bit.sv
// rtl/RCA_8Bit.sv - 8-bit ripple-carry adder datapath shared by the serial sequencer
module RCA_8Bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       c
);

    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c = carry[8];

endmodule

// File: rtl/rca_serial_add_ctrl.sv
// rtl/rca_serial_add_ctrl.sv - wide adder built by walking bytes LSB-first through one RCA_8Bit
module rca_serial_add_ctrl
    import rca_serial_add_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               carry_r;
    logic               cout_r;
    logic               ovf_r;
    logic [BYTE_W-1:0]  byte_a;
    logic [BYTE_W-1:0]  byte_b;
    logic [BYTE_W-1:0]  byte_s;
    logic               byte_c;
    logic               accept;
    logic               last;

    assign byte_a = a_r[idx*BYTE_W +: BYTE_W];
    assign byte_b = b_r[idx*BYTE_W +: BYTE_W];
    assign last   = (idx == LAST_IDX);
    // A new request may land in DONE as well as IDLE so back-to-back ops need no bubble.
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    RCA_8Bit u_rca (
        .a   (byte_a),
        .b   (byte_b),
        .cin (carry_r),
        .s   (byte_s),
        .c   (byte_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ADD;
            S_ADD:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_ADD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx     <= '0;
        end else if (state == S_ADD) begin
            sum_r[idx*BYTE_W +: BYTE_W] <= byte_s;
            carry_r <= byte_c;
            if (last) begin
                idx    <= '0;
                cout_r <= byte_c;
                // Overflow uses the freshly computed MSB byte, not the stale sum_r value.
                ovf_r  <= (a_r[W-1] == b_r[W-1]) && (byte_s[BYTE_W-1] != a_r[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign busy = (state == S_ADD);
    assign done = (state == S_DONE);
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
